// File: rtl/reg_pkg.sv
// Shared sizing constants for the physical register file.
//   WORD_SIZE     : data width in bits
//   NUM_PHYS_REGS : number of physical registers (need not be a power of 2)
package reg_pkg;
  parameter int WORD_SIZE     = 16;
  parameter int NUM_PHYS_REGS = 48;
endpackage

// File: rtl/reg_file_bypass.sv
// Physical register file with per-register ready (scoreboard) bits,
// write-to-read bypass, 0- or 1-cycle read latency and an optional
// hardwired zero register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   read_en/read_index    per read port: enable and register select
//   read_data/read_ready  per read port: value and ready bit of the selection
//   write_en/write_index/write_data   writeback buses (sets ready)
//   alloc_en/alloc_index  allocate ports (clears ready, data unchanged)
//   conflict_err          sticky conflict flag (only with the macro below)
//
// Build option:
//   REG_FILE_CONFLICT_CHECK_EN  adds conflict_err and its checker. Without it
//   conflicts resolve silently: highest write port wins, allocate beats write
//   for the ready bit.
module reg_file_bypass #(
  parameter int WORD_SIZE       = reg_pkg::WORD_SIZE,
  parameter int NUM_PHYS_REGS   = reg_pkg::NUM_PHYS_REGS,
  parameter int NUM_READ_PORTS  = 4,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int NUM_ALLOC_PORTS = 2,
  parameter int READ_LATENCY    = 0,
  parameter int ZERO_REG        = 1,
  localparam int IDX_W          = $clog2(NUM_PHYS_REGS)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_READ_PORTS-1:0]                    read_en,
  input  logic [NUM_READ_PORTS-1:0][IDX_W-1:0]         read_index,
  output logic [NUM_READ_PORTS-1:0][WORD_SIZE-1:0]     read_data,
  output logic [NUM_READ_PORTS-1:0]                    read_ready,
  input  logic [NUM_WRITE_PORTS-1:0]                   write_en,
  input  logic [NUM_WRITE_PORTS-1:0][IDX_W-1:0]        write_index,
  input  logic [NUM_WRITE_PORTS-1:0][WORD_SIZE-1:0]    write_data,
  input  logic [NUM_ALLOC_PORTS-1:0]                   alloc_en,
  input  logic [NUM_ALLOC_PORTS-1:0][IDX_W-1:0]        alloc_index
`ifdef REG_FILE_CONFLICT_CHECK_EN
  ,
  output logic                                         conflict_err
`endif
);

  if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
    $error("reg_file_bypass: READ_LATENCY must be 0 or 1");
  end

  localparam logic [IDX_W:0] NREGS_W = (IDX_W+1)'(NUM_PHYS_REGS);

  logic [NUM_PHYS_REGS-1:0][WORD_SIZE-1:0] mem;
  logic [NUM_PHYS_REGS-1:0]                ready_q;

  logic [NUM_READ_PORTS-1:0][WORD_SIZE-1:0] rd_data_c;
  logic [NUM_READ_PORTS-1:0]                rd_ready_c;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NREGS_W;
  endfunction

  function automatic logic is_zero_reg(input logic [IDX_W-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Writable/allocatable: a real register that is not the hardwired zero.
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return in_range(idx) && !is_zero_reg(idx);
  endfunction

  // Writes in ascending port order so the highest port's NBA lands last;
  // allocates follow so a same-cycle allocate leaves the ready bit clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem     <= '0;
      ready_q <= '1;
    end else begin
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (write_en[w] && idx_ok(write_index[w])) begin
          mem[write_index[w]]     <= write_data[w];
          ready_q[write_index[w]] <= 1'b1;
        end
      end
      for (int a = 0; a < NUM_ALLOC_PORTS; a++) begin
        if (alloc_en[a] && idx_ok(alloc_index[a])) begin
          ready_q[alloc_index[a]] <= 1'b0;
        end
      end
    end
  end

  // Read resolution shared by both latencies. Bypass scans write ports in
  // ascending order so the highest-numbered matching port ends up selected.
  always_comb begin
    rd_data_c  = '0;
    rd_ready_c = '0;
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      if (read_en[r] && in_range(read_index[r])) begin
        if (is_zero_reg(read_index[r])) begin
          rd_ready_c[r] = 1'b1;
        end else begin
          rd_data_c[r]  = mem[read_index[r]];
          rd_ready_c[r] = ready_q[read_index[r]];
          for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
            if (write_en[w] && (write_index[w] == read_index[r])) begin
              rd_data_c[r]  = write_data[w];
              rd_ready_c[r] = 1'b1;
            end
          end
        end
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb_read
    // The array resets to ready=1, so outputs are forced low while in reset.
    assign read_data  = rst_n ? rd_data_c  : '0;
    assign read_ready = rst_n ? rd_ready_c : '0;
  end else begin : g_reg_read
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        read_data  <= '0;
        read_ready <= '0;
      end else begin
        read_data  <= rd_data_c;
        read_ready <= rd_ready_c;
      end
    end
  end

`ifdef REG_FILE_CONFLICT_CHECK_EN
  logic conflict_c;

  // Out-of-range indices are dropped by the array, so they are not checked.
  always_comb begin
    conflict_c = 1'b0;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      if (write_en[w] && idx_ok(write_index[w])) begin
        if (ready_q[write_index[w]]) conflict_c = 1'b1;
        for (int v = w + 1; v < NUM_WRITE_PORTS; v++) begin
          if (write_en[v] && (write_index[v] == write_index[w])) conflict_c = 1'b1;
        end
      end
    end
    for (int a = 0; a < NUM_ALLOC_PORTS; a++) begin
      if (alloc_en[a] && idx_ok(alloc_index[a])) begin
        for (int b = a + 1; b < NUM_ALLOC_PORTS; b++) begin
          if (alloc_en[b] && (alloc_index[b] == alloc_index[a])) conflict_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_err <= 1'b0;
    end else if (conflict_c) begin
      conflict_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_bypass.sv
module tb_reg_file_bypass;
  localparam int WS    = reg_pkg::WORD_SIZE;
  localparam int NREGS = reg_pkg::NUM_PHYS_REGS;
  localparam int IW    = $clog2(NREGS);
  localparam int NR    = 4;
  localparam int NW    = 2;
  localparam int NA    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0]          read_en;
  logic [NR-1:0][IW-1:0]  read_index;
  logic [NW-1:0]          write_en;
  logic [NW-1:0][IW-1:0]  write_index;
  logic [NW-1:0][WS-1:0]  write_data;
  logic [NA-1:0]          alloc_en;
  logic [NA-1:0][IW-1:0]  alloc_index;
  logic [NR-1:0][WS-1:0]  rd_data0, rd_data1;
  logic [NR-1:0]          rd_ready0, rd_ready1;
`ifdef REG_FILE_CONFLICT_CHECK_EN
  logic conf0, conf1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_bypass #(.READ_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .read_en(read_en), .read_index(read_index),
    .read_data(rd_data0), .read_ready(rd_ready0),
    .write_en(write_en), .write_index(write_index), .write_data(write_data),
    .alloc_en(alloc_en), .alloc_index(alloc_index)
`ifdef REG_FILE_CONFLICT_CHECK_EN
    , .conflict_err(conf0)
`endif
  );

  reg_file_bypass #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .read_en(read_en), .read_index(read_index),
    .read_data(rd_data1), .read_ready(rd_ready1),
    .write_en(write_en), .write_index(write_index), .write_data(write_data),
    .alloc_en(alloc_en), .alloc_index(alloc_index)
`ifdef REG_FILE_CONFLICT_CHECK_EN
    , .conflict_err(conf1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: an array of values plus a busy/ready flag per register.
  logic [WS-1:0]         m_mem [NREGS];
  logic [NREGS-1:0]      m_rdy;
  logic [NR-1:0][WS-1:0] exp1_d;
  logic [NR-1:0]         exp1_r;

  // What a read port must return right now (latency 0 semantics).
  function automatic logic [WS-1:0] model_data(input int r);
    int idx = int'(read_index[r]);
    if (!read_en[r] || idx >= NREGS || idx == 0) return '0;
    for (int w = NW - 1; w >= 0; w--)
      if (write_en[w] && int'(write_index[w]) == idx) return write_data[w];
    return m_mem[idx];
  endfunction

  function automatic logic model_ready(input int r);
    int idx = int'(read_index[r]);
    if (!read_en[r] || idx >= NREGS) return 1'b0;
    if (idx == 0) return 1'b1;
    for (int w = 0; w < NW; w++)
      if (write_en[w] && int'(write_index[w]) == idx) return 1'b1;
    return m_rdy[idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) m_mem[i] <= '0;
      m_rdy  <= '1;
      exp1_d <= '0;
      exp1_r <= '0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        exp1_d[r] <= model_data(r);
        exp1_r[r] <= model_ready(r);
      end
      for (int w = 0; w < NW; w++)
        if (write_en[w] && int'(write_index[w]) < NREGS && write_index[w] != '0) begin
          m_mem[write_index[w]] <= write_data[w];
          m_rdy[write_index[w]] <= 1'b1;
        end
      for (int a = 0; a < NA; a++)
        if (alloc_en[a] && int'(alloc_index[a]) < NREGS && alloc_index[a] != '0)
          m_rdy[alloc_index[a]] <= 1'b0;
    end
  end

  // Every-cycle comparison of both latencies against the model.
  always @(negedge clk) begin
    for (int r = 0; r < NR; r++) begin
      check($sformatf("lat0_data[%0d]", r), 64'(rd_data0[r]), rst_n ? 64'(model_data(r)) : 64'd0);
      check($sformatf("lat0_ready[%0d]", r), 64'(rd_ready0[r]), rst_n ? 64'(model_ready(r)) : 64'd0);
      check($sformatf("lat1_data[%0d]", r), 64'(rd_data1[r]), rst_n ? 64'(exp1_d[r]) : 64'd0);
      check($sformatf("lat1_ready[%0d]", r), 64'(rd_ready1[r]), rst_n ? 64'(exp1_r[r]) : 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    read_en = '0; read_index = '0;
    write_en = '0; write_index = '0; write_data = '0;
    alloc_en = '0; alloc_index = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    read_en = '1;
    read_index[0] = IW'(1); read_index[1] = IW'(2);
    read_index[2] = IW'(3); read_index[3] = IW'(4);
    repeat (2) @(negedge clk);
    check("reset_ready_low", 64'(rd_ready0), 64'd0);
    #1 rst_n = 1'b1;

    // Reset state: registers 1..4 read zero and ready.
    step();
    read_en = '1;
    read_index[0] = IW'(1); read_index[1] = IW'(2);
    read_index[2] = IW'(3); read_index[3] = IW'(4);
    @(negedge clk);
    check("A_data", 64'(rd_data0), 64'd0);
    check("A_ready", 64'(rd_ready0), 64'hF);

    // Allocate 5, read busy, then write with same-cycle bypass.
    step(); alloc_en[0] = 1'b1; alloc_index[0] = IW'(5);
    @(negedge clk);
    step(); read_en[0] = 1'b1; read_index[0] = IW'(5);
    @(negedge clk);
    check("B_busy_ready", 64'(rd_ready0[0]), 64'd0);
    step(); read_en[0] = 1'b1; read_index[0] = IW'(5);
    write_en[0] = 1'b1; write_index[0] = IW'(5); write_data[0] = WS'('hDEAD);
    @(negedge clk);
    check("B_bypass_data", 64'(rd_data0[0]), 64'hDEAD);
    check("B_bypass_ready", 64'(rd_ready0[0]), 64'd1);
    check("B_lat1_busy", 64'(rd_ready1[0]), 64'd0);
    step();
    @(negedge clk);
    check("B_lat1_data", 64'(rd_data1[0]), 64'hDEAD);
    check("B_lat1_ready", 64'(rd_ready1[0]), 64'd1);

    // Registered read: write-at-t bypassed, write-at-t+1 invisible.
    step(); alloc_en[1] = 1'b1; alloc_index[1] = IW'(7);
    @(negedge clk);
    step(); alloc_en[1] = 1'b1; alloc_index[1] = IW'(7);
    write_en[1] = 1'b1; write_index[1] = IW'(7); write_data[1] = WS'('h1234);
    read_en[1] = 1'b1; read_index[1] = IW'(7);
    @(negedge clk);
    check("C_lat0_data", 64'(rd_data0[1]), 64'h1234);
    step(); write_en[0] = 1'b1; write_index[0] = IW'(7); write_data[0] = WS'('h5678);
    @(negedge clk);
    check("C_lat1_data", 64'(rd_data1[1]), 64'h1234);
    check("C_lat1_ready", 64'(rd_ready1[1]), 64'd1);
    step(); read_en[1] = 1'b1; read_index[1] = IW'(7);
    @(negedge clk);
    check("C_new_data", 64'(rd_data0[1]), 64'h5678);
    check("C_new_ready", 64'(rd_ready0[1]), 64'd1);
    check("C_lat1_disabled", 64'(rd_data1[1]), 64'd0);

    // Zero register ignores writes, allocates and bypass.
    step(); write_en[1] = 1'b1; write_index[1] = '0; write_data[1] = WS'('hFFFF);
    read_en[3] = 1'b1; read_index[3] = '0;
    @(negedge clk);
    check("E_bypass_zero", 64'(rd_data0[3]), 64'd0);
    step(); alloc_en[0] = 1'b1; alloc_index[0] = '0;
    @(negedge clk);
    step(); read_en[3] = 1'b1; read_index[3] = '0;
    @(negedge clk);
    check("E_zero_data", 64'(rd_data0[3]), 64'd0);
    check("E_zero_ready", 64'(rd_ready0[3]), 64'd1);
`ifdef REG_FILE_CONFLICT_CHECK_EN
    check("E_no_conflict", 64'(conf0), 64'd0);
`endif

    // Two write ports to 9: port 1 wins.
    step(); write_en = 2'b11;
    write_index[0] = IW'(9); write_data[0] = WS'('hAA);
    write_index[1] = IW'(9); write_data[1] = WS'('hBB);
    read_en[2] = 1'b1; read_index[2] = IW'(9);
    @(negedge clk);
    check("D_bypass_hi_port", 64'(rd_data0[2]), 64'hBB);
    step(); read_en[2] = 1'b1; read_index[2] = IW'(9);
    @(negedge clk);
    check("D_array_hi_port", 64'(rd_data0[2]), 64'hBB);
    check("D_lat1_hi_port", 64'(rd_data1[2]), 64'hBB);
`ifdef REG_FILE_CONFLICT_CHECK_EN
    check("D_conflict_set", 64'(conf0), 64'd1);
`endif

    // Allocate and write 3 together: data lands, ready stays 0.
    step(); alloc_en[0] = 1'b1; alloc_index[0] = IW'(3);
    write_en[0] = 1'b1; write_index[0] = IW'(3); write_data[0] = WS'('h42);
    @(negedge clk);
    step(); read_en[0] = 1'b1; read_index[0] = IW'(3);
    @(negedge clk);
    check("F_data", 64'(rd_data0[0]), 64'h42);
    check("F_ready", 64'(rd_ready0[0]), 64'd0);

    // Out-of-range index (50 >= 48): dropped, reads 0 / not ready.
    step(); write_en[1] = 1'b1; write_index[1] = IW'(50); write_data[1] = WS'('h1111);
    alloc_en[1] = 1'b1; alloc_index[1] = IW'(50);
    read_en[0] = 1'b1; read_index[0] = IW'(50);
    @(negedge clk);
    check("G_oor_data", 64'(rd_data0[0]), 64'd0);
    check("G_oor_ready", 64'(rd_ready0[0]), 64'd0);

    // Mixed traffic, checked by the model every cycle.
    for (int i = 0; i < 16; i++) begin
      step();
      for (int r = 0; r < NR; r++) begin
        read_en[r]    = ((i + r) % 3) != 0;
        read_index[r] = IW'((i + r) % 10);
      end
      write_en[0] = 1'b1; write_index[0] = IW'((i % 6) + 1); write_data[0] = WS'(16'h100 + i);
      write_en[1] = (i % 2) == 1; write_index[1] = IW'((i % 4) + 8); write_data[1] = WS'(16'h200 + i);
      alloc_en[0] = (i % 3) == 0; alloc_index[0] = IW'((i % 5) + 1);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle clears both latencies at once.
    step(); read_en[0] = 1'b1; read_index[0] = IW'(7);
    @(negedge clk);
    step(); read_en[0] = 1'b1; read_index[0] = IW'(7);
    @(negedge clk);
    check("H_pre_lat0", 64'(rd_data0[0]), 64'h5678);
    check("H_pre_lat1", 64'(rd_data1[0]), 64'h5678);
    #2 rst_n = 1'b0;
    #1;
    check("H_rst_lat0_data", 64'(rd_data0), 64'd0);
    check("H_rst_lat0_ready", 64'(rd_ready0), 64'd0);
    check("H_rst_lat1_data", 64'(rd_data1), 64'd0);
    check("H_rst_lat1_ready", 64'(rd_ready1), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(); read_en[0] = 1'b1; read_index[0] = IW'(7);
    @(negedge clk);
    check("H_post_data", 64'(rd_data0[0]), 64'd0);
    check("H_post_ready", 64'(rd_ready0[0]), 64'd1);
`ifdef REG_FILE_CONFLICT_CHECK_EN
    check("H_conflict_cleared", 64'(conf0), 64'd0);
`endif
    step();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_bypass.md
Name: reg_file_bypass

Overview:
- Parametrised next-generation physical register file for the backend: N read ports, M write ports and A allocate ports.
- Per-register ready (scoreboard) bit, cleared on allocate and set on writeback.
- Write-to-read bypass, selectable 0- or 1-cycle read latency and an optional hardwired zero register.
- Sits between rename/issue (allocate, read) and the execute writeback buses (write).

Parameters:
- WORD_SIZE, reg_pkg::WORD_SIZE, data width in bits.
- NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS, register count; IDX_W = $clog2(NUM_PHYS_REGS).
- NUM_READ_PORTS, 4, read ports.
- NUM_WRITE_PORTS, 2, writeback ports.
- NUM_ALLOC_PORTS, 2, allocate ports (ready-bit clear).
- READ_LATENCY, 0, 0 = combinational read; 1 = registered read. Other values are illegal (elaboration $error).
- ZERO_REG, 1, 1 = register 0 always reads 0, is always ready, and ignores writes and allocates.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- read_en  in  [NUM_READ_PORTS]x1  read enable per port
- read_index  in  [NUM_READ_PORTS]xIDX_W  register selected per port
- read_data  out  [NUM_READ_PORTS]xWORD_SIZE  read value
- read_ready  out  [NUM_READ_PORTS]x1  ready bit of the selected register
- write_en  in  [NUM_WRITE_PORTS]x1  writeback valid
- write_index  in  [NUM_WRITE_PORTS]xIDX_W  writeback destination
- write_data  in  [NUM_WRITE_PORTS]xWORD_SIZE  writeback value
- alloc_en  in  [NUM_ALLOC_PORTS]x1  allocate valid (marks register busy)
- alloc_index  in  [NUM_ALLOC_PORTS]xIDX_W  allocated register
- conflict_err  out  1  sticky error flag; present only with REG_FILE_CONFLICT_CHECK_EN

Behaviour:
- Reset: rst_n low asynchronously clears all registers to 0 and sets all ready bits to 1. read_data is 0 and read_ready is 0 on all ports; for READ_LATENCY=1, the output registers are also cleared. Reset mid-operation discards all in-flight reads.
- Write: at posedge, each enabled write port stores write_data into write_index and sets its ready bit. If several write ports target the same index, the highest-numbered port wins both data and bypass.
- Allocate: at posedge, each enabled allocate port clears the ready bit of alloc_index. Data is unchanged.
- Allocate and write to the same index in the same cycle: data is written and the ready bit ends at 0 (allocate wins).
- Read, READ_LATENCY=0: combinational.
  - read_en=0 gives read_data=0 and read_ready=0.
  - Otherwise the result comes from the array, except that a same-cycle enabled write to the same index is bypassed: read_data=write_data and read_ready=1.
  - Same-cycle allocates do not affect the read result.
- Read, READ_LATENCY=1: index and bypass are resolved at posedge t; read_data/read_ready are valid throughout cycle t+1.
  - A write in cycle t is bypassed.
  - A write in cycle t+1 is not visible until the next read.
  - read_en=0 at t gives zeros at t+1.
- ZERO_REG=1:
  - A read of index 0 gives data 0 and ready 1, regardless of any bypass.
  - Writes and allocates to index 0 are dropped.
- Reading and writing the same register through different ports in one cycle is legal. No stalls; all ports are serviced every cycle.
- Index values at or above NUM_PHYS_REGS (non-power-of-2 sizes): writes and allocates are dropped; reads return 0 with ready 0.

Optional Feature:
REG_FILE_CONFLICT_CHECK_EN
- Defined: conflict_err exists, resets to 0, and sets at the posedge after any of:
  - two enabled write ports with the same index;
  - a write to a register whose ready bit is 1 (write without prior allocate);
  - two enabled allocate ports with the same index.
- Defined: the flag stays set until rst_n. Index 0 under ZERO_REG=1 is exempt from all checks.
- Undefined: the port and checker logic are absent; conflicts resolve silently per the priority rules above.

Test Plan:
- Reset, then read ports 0-3 at indices 1,2,3,4 -> data 0, ready 1 on all.
- Allocate reg 5 at cycle 0; read 5 at cycle 1 -> ready 0. Write 5 = 0xDEAD at cycle 2 with a same-cycle read of 5 -> data 0xDEAD, ready 1 (bypass, latency 0).
- READ_LATENCY=1: write 7 = 0x1234 and read 7 at the same posedge -> 0x1234 the next cycle. Write 7 = 0x5678 one cycle later -> that read still shows 0x1234.
- Ports 0 and 1 both write reg 9 (0xAA, 0xBB) -> reads 0xBB. With the macro defined, conflict_err=1 the next cycle and stays 1 until reset.
- ZERO_REG=1: write 0 = 0xFFFF, then allocate 0 -> a read of 0 gives data 0, ready 1, and conflict_err stays 0.
- Allocate and write reg 3 = 0x42 in the same cycle -> next read gives data 0x42, ready 0. Assert rst_n low mid-stream -> outputs go to 0 immediately, without waiting for a clock edge.
